// File: rtl/tlm_pkg.sv
// tlm_pkg: phase and fault encodings plus the phase-transition legality rule
// shared by the traffic light monitor.
package tlm_pkg;

    typedef enum logic [2:0] {
        PH_G1     = 3'd0,
        PH_Y1     = 3'd1,
        PH_G2     = 3'd2,
        PH_Y2     = 3'd3,
        PH_ALLRED = 3'd4,
        PH_BAD    = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE      = 3'd0,
        FC_CONFLICT  = 3'd1,
        FC_MALFORMED = 3'd2,
        FC_ILLEGAL   = 3'd3,
        FC_MINDWELL  = 3'd4,
        FC_STUCK     = 3'd5
    } fault_e;

    // Leaving BAD for any decoded phase is accepted; the malformed or
    // conflicting pattern has already been reported on the way in.
    function automatic logic legal_next(input logic [2:0] prev, input logic [2:0] nxt,
                                        input logic emg, input logic allow);
        logic ok;
        case (prev)
            PH_G1:     ok = nxt == PH_Y1;
            PH_Y1:     ok = nxt == PH_G2 || nxt == PH_ALLRED;
            PH_G2:     ok = nxt == PH_Y2 || (allow && nxt == PH_G1);
            PH_Y2:     ok = nxt == PH_G1 || nxt == PH_ALLRED;
            PH_ALLRED: ok = nxt == PH_G1 || nxt == PH_G2;
            default:   ok = nxt != PH_BAD;
        endcase
        return ok || nxt == prev || (emg && nxt == PH_G2);
    endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// tl_lamp_decode: maps a registered lamp sample {R1,Y1,G1,R2,Y2,G2} to a phase
// and flags conflicting or malformed lamp patterns.
module tl_lamp_decode
    import tlm_pkg::*;
(
    input  logic [5:0] lamp_i,
    output logic [2:0] phase_o,
    output logic       conflict_o,
    output logic       malformed_o
);

    assign phase_o = lamp_i == 6'b001_100 ? PH_G1 :
                     lamp_i == 6'b010_100 ? PH_Y1 :
                     lamp_i == 6'b100_001 ? PH_G2 :
                     lamp_i == 6'b100_010 ? PH_Y2 :
                     lamp_i == 6'b100_100 ? PH_ALLRED : PH_BAD;

    assign conflict_o  = (lamp_i[4] | lamp_i[3]) & (lamp_i[1] | lamp_i[0]);
    assign malformed_o = !($onehot(lamp_i[5:3]) && $onehot(lamp_i[2:0]));

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the intersection lamp drive; decodes
// phase, measures dwell, counts cycles and latches the first fault code.
module traffic_light_monitor
    import tlm_pkg::*;
#(
    parameter int MIN_GREEN      = 1,
    parameter int MIN_YELLOW     = 1,
    parameter int MAX_DWELL      = 0,
    parameter bit ALLOW_G2_TO_G1 = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             R1,
    input  logic             Y1,
    input  logic             G1,
    input  logic             R2,
    input  logic             Y2,
    input  logic             G2,
    input  logic             emergency,
    input  logic             fault_clr,
    output logic [2:0]       phase,
    output logic             phase_vld,
    output logic             phase_chg,
    output logic [CNT_W-1:0] dwell,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             fault,
    output logic [2:0]       fault_code
);

    logic [5:0]       lamp_q;
    logic             emg_q, s1_vld_q, first_q, first_d;
    logic [2:0]       phase_q, phase_d, code_q, code_d, new_code, dec_phase;
    logic             vld_q, vld_d, chg_q, chg_d, fault_q, fault_d;
    logic [CNT_W-1:0] dwell_q, dwell_d, cyc_q, cyc_d, min_lim;
    logic             conflict, malformed, illegal, short_dwell, stuck;

    tl_lamp_decode u_dec (
        .lamp_i      (lamp_q),
        .phase_o     (dec_phase),
        .conflict_o  (conflict),
        .malformed_o (malformed)
    );

    // s1_vld_q keeps the reset-time lamp_q contents out of stage 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp_q   <= '0;
            emg_q    <= 1'b0;
            s1_vld_q <= 1'b0;
        end else begin
            lamp_q   <= {R1, Y1, G1, R2, Y2, G2};
            emg_q    <= emergency;
            s1_vld_q <= 1'b1;
        end
    end

    always_comb begin
        chg_d       = s1_vld_q && !first_q && dec_phase != phase_q;
        illegal     = chg_d && !legal_next(phase_q, dec_phase, emg_q, ALLOW_G2_TO_G1);
        min_lim     = (phase_q == PH_G1 || phase_q == PH_G2) ? CNT_W'(MIN_GREEN) :
                      (phase_q == PH_Y1 || phase_q == PH_Y2) ? CNT_W'(MIN_YELLOW) : '0;
        short_dwell = chg_d && !emg_q && dwell_q < min_lim;
        dwell_d     = !s1_vld_q ? dwell_q :
                      (first_q || chg_d) ? CNT_W'(1) :
                      &dwell_q ? dwell_q : dwell_q + 1'b1;
        // the equality with MAX_DWELL holds for only one cycle per occupancy
        stuck       = s1_vld_q && MAX_DWELL != 0 && dwell_d == CNT_W'(MAX_DWELL) &&
                      (first_q || chg_d || dwell_d != dwell_q);
        new_code    = !s1_vld_q  ? FC_NONE :
                      conflict    ? FC_CONFLICT :
                      malformed   ? FC_MALFORMED :
                      illegal     ? FC_ILLEGAL :
                      short_dwell ? FC_MINDWELL :
                      stuck       ? FC_STUCK : FC_NONE;
        fault_d     = (new_code != FC_NONE && (!fault_q || fault_clr)) ? 1'b1 :
                      fault_clr ? 1'b0 : fault_q;
        code_d      = (new_code != FC_NONE && (!fault_q || fault_clr)) ? new_code :
                      fault_clr ? FC_NONE : code_q;
        phase_d     = s1_vld_q ? dec_phase : phase_q;
        vld_d       = s1_vld_q | vld_q;
        cyc_d       = cyc_q + CNT_W'(chg_d && dec_phase == PH_G1 && phase_q != PH_BAD);
        first_d     = first_q && !s1_vld_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_BAD;
            vld_q   <= 1'b0;
            chg_q   <= 1'b0;
            dwell_q <= '0;
            cyc_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            first_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
            vld_q   <= vld_d;
            chg_q   <= chg_d;
            dwell_q <= dwell_d;
            cyc_q   <= cyc_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            first_q <= first_d;
        end
    end

    assign phase      = phase_q;
    assign phase_vld  = vld_q;
    assign phase_chg  = chg_q;
    assign dwell      = dwell_q;
    assign cycle_cnt  = cyc_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: two monitor instances (default and tight dwell limits)
// driven by directed and random lamp sequences, checked against a table-driven model.
module tb_traffic_light_monitor;

    localparam logic [5:0] P_G1 = 6'b001_100, P_Y1 = 6'b010_100, P_G2 = 6'b100_001;
    localparam logic [5:0] P_Y2 = 6'b100_010, P_AR = 6'b100_100, P_DARK = 6'b000_000;
    localparam logic [5:0] P_CONF = 6'b001_001;

    typedef struct {
        bit          s1v;
        logic [5:0]  lamp;
        bit          emg;
        bit          first;
        logic [2:0]  phase;
        bit          vld;
        bit          chg;
        logic [15:0] dwell;
        logic [15:0] cyc;
        bit          fault;
        logic [2:0]  code;
    } mst_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  lamps = '0;
    logic        emergency = 1'b0, fault_clr = 1'b0;
    logic [2:0]  a_phase, a_code, b_phase, b_code;
    logic        a_vld, a_chg, a_fault, b_vld, b_chg, b_fault;
    logic [15:0] a_dwell, a_cyc, b_dwell, b_cyc;

    logic [2:0]  dec_t [64];
    bit          legal_t [8][8];
    logic [5:0]  pats [5];
    mst_t        ma, mb;
    int          passes = 0, total = 0;
    int          r, ci;
    logic [5:0]  pat;

    always #5 clk = ~clk;

    traffic_light_monitor dut_a (
        .clk(clk), .reset(reset),
        .R1(lamps[5]), .Y1(lamps[4]), .G1(lamps[3]), .R2(lamps[2]), .Y2(lamps[1]), .G2(lamps[0]),
        .emergency(emergency), .fault_clr(fault_clr),
        .phase(a_phase), .phase_vld(a_vld), .phase_chg(a_chg), .dwell(a_dwell),
        .cycle_cnt(a_cyc), .fault(a_fault), .fault_code(a_code)
    );

    traffic_light_monitor #(.MIN_GREEN(3), .MIN_YELLOW(1), .MAX_DWELL(5)) dut_b (
        .clk(clk), .reset(reset),
        .R1(lamps[5]), .Y1(lamps[4]), .G1(lamps[3]), .R2(lamps[2]), .Y2(lamps[1]), .G2(lamps[0]),
        .emergency(emergency), .fault_clr(fault_clr),
        .phase(b_phase), .phase_vld(b_vld), .phase_chg(b_chg), .dwell(b_dwell),
        .cycle_cnt(b_cyc), .fault(b_fault), .fault_code(b_code)
    );

    function automatic mst_t mreset();
        mst_t s;
        s.s1v = 0; s.lamp = '0; s.emg = 0; s.first = 1; s.phase = 3'd7; s.vld = 0;
        s.chg = 0; s.dwell = '0; s.cyc = '0; s.fault = 0; s.code = '0;
        return s;
    endfunction

    // One clock of the observer: judge the previously captured sample, then capture the new one.
    function automatic mst_t mstep(mst_t s, logic [5:0] lamp_in, bit emg_in, bit clr,
                                   int min_g, int min_y, int max_d, bit allow);
        mst_t n = s;
        logic [2:0] p;
        bit conflict, malformed, illegal, short_d, stuck, moved;
        int need, code;
        code = 0;
        n.chg = 0;
        if (s.s1v) begin
            p = dec_t[s.lamp];
            moved = !s.first && p != s.phase;
            conflict = (s.lamp[4:3] != 0) && (s.lamp[1:0] != 0);
            malformed = $countones(s.lamp[5:3]) != 1 || $countones(s.lamp[2:0]) != 1;
            illegal = 0;
            short_d = 0;
            if (moved) begin
                illegal = !(legal_t[s.phase][p] || (allow && s.phase == 2 && p == 0) || (s.emg && p == 2));
                need = (s.phase == 0 || s.phase == 2) ? min_g : (s.phase == 1 || s.phase == 3) ? min_y : 0;
                short_d = !s.emg && int'(s.dwell) < need;
                if (p == 0 && s.phase != 7) n.cyc = s.cyc + 16'd1;
            end
            n.dwell = (s.first || moved) ? 16'd1 : (s.dwell == 16'hFFFF) ? s.dwell : s.dwell + 16'd1;
            stuck = max_d != 0 && int'(n.dwell) == max_d && (s.first || moved || n.dwell != s.dwell);
            code = conflict ? 1 : malformed ? 2 : illegal ? 3 : short_d ? 4 : stuck ? 5 : 0;
            n.phase = p;
            n.vld = 1;
            n.chg = moved;
            n.first = 0;
        end
        if (code != 0 && (!s.fault || clr)) begin
            n.fault = 1;
            n.code = 3'(code);
        end else if (clr) begin
            n.fault = 0;
            n.code = '0;
        end
        n.s1v = 1;
        n.lamp = lamp_in;
        n.emg = emg_in;
        return n;
    endfunction

    function automatic int succ(int c);
        bit b = 1'($urandom_range(0, 1));
        case (c)
            0: return 1;
            1: return b ? 2 : 4;
            2: return b ? 3 : 0;
            3: return b ? 0 : 4;
            default: return b ? 0 : 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cmp_all();
        chk("a_phase", 16'(a_phase), 16'(ma.phase));
        chk("a_vld", 16'(a_vld), 16'(ma.vld));
        chk("a_chg", 16'(a_chg), 16'(ma.chg));
        chk("a_dwell", a_dwell, ma.dwell);
        chk("a_cyc", a_cyc, ma.cyc);
        chk("a_fault", 16'(a_fault), 16'(ma.fault));
        chk("a_code", 16'(a_code), 16'(ma.code));
        chk("b_phase", 16'(b_phase), 16'(mb.phase));
        chk("b_vld", 16'(b_vld), 16'(mb.vld));
        chk("b_chg", 16'(b_chg), 16'(mb.chg));
        chk("b_dwell", b_dwell, mb.dwell);
        chk("b_cyc", b_cyc, mb.cyc);
        chk("b_fault", 16'(b_fault), 16'(mb.fault));
        chk("b_code", 16'(b_code), 16'(mb.code));
    endtask

    task automatic chk_reset();
        chk("rst_a_phase", 16'(a_phase), 16'd7);
        chk("rst_a_vld", 16'(a_vld), 16'd0);
        chk("rst_a_chg", 16'(a_chg), 16'd0);
        chk("rst_a_dwell", a_dwell, 16'd0);
        chk("rst_a_cyc", a_cyc, 16'd0);
        chk("rst_a_fault", 16'(a_fault), 16'd0);
        chk("rst_a_code", 16'(a_code), 16'd0);
        chk("rst_b_phase", 16'(b_phase), 16'd7);
        chk("rst_b_dwell", b_dwell, 16'd0);
        chk("rst_b_cyc", b_cyc, 16'd0);
        chk("rst_b_fault", 16'(b_fault), 16'd0);
        chk("rst_b_code", 16'(b_code), 16'd0);
    endtask

    task automatic step(input logic [5:0] l, input bit e = 0, input bit c = 0);
        lamps = l;
        emergency = e;
        fault_clr = c;
        @(posedge clk);
        ma = mstep(ma, l, e, c, 1, 1, 0, 1);
        mb = mstep(mb, l, e, c, 3, 1, 5, 1);
        #1;
        cmp_all();
    endtask

    // Asserted between edges so the outputs must clear without waiting for a clock.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1 chk_reset();
        ma = mreset();
        mb = mreset();
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dec_t[i] = 3'd7;
        dec_t[P_G1] = 3'd0; dec_t[P_Y1] = 3'd1; dec_t[P_G2] = 3'd2; dec_t[P_Y2] = 3'd3; dec_t[P_AR] = 3'd4;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) legal_t[i][j] = (i == j);
        legal_t[0][1] = 1; legal_t[1][2] = 1; legal_t[1][4] = 1; legal_t[2][3] = 1;
        legal_t[3][0] = 1; legal_t[3][4] = 1; legal_t[4][0] = 1; legal_t[4][2] = 1;
        for (int j = 0; j < 5; j++) legal_t[7][j] = 1;
        pats[0] = P_G1; pats[1] = P_Y1; pats[2] = P_G2; pats[3] = P_Y2; pats[4] = P_AR;
        ma = mreset();
        mb = mreset();
        #1 reset = 1'b1;
        #1 chk_reset();
        @(negedge clk) reset = 1'b0;

        // normal G1/Y1/G2 rotation
        repeat (4) begin
            step(P_G1); step(P_Y1); step(P_G2);
        end
        step(P_G1);
        chk("t1_cyc", a_cyc, 16'd3);
        chk("t1_fault", 16'(a_fault), 16'd0);
        chk("t1_chg", 16'(a_chg), 16'd1);

        // conflicting greens, sticky until cleared
        step(P_CONF); step(P_G1);
        chk("t2_fault", 16'(a_fault), 16'd1);
        chk("t2_code", 16'(a_code), 16'd1);
        step(P_Y1); step(P_G2);
        chk("t2_sticky", 16'(a_code), 16'd1);
        step(P_Y2, 0, 1);
        chk("t2_clr_fault", 16'(a_fault), 16'd0);
        chk("t2_clr_code", 16'(a_code), 16'd0);
        step(P_G1);

        // direct G1->G2 without and with emergency
        step(P_G2); step(P_Y2);
        chk("t3_code", 16'(a_code), 16'd3);
        step(P_G1, 0, 1);
        step(P_G2, 1); step(P_Y2);
        chk("t3_emg_fault", 16'(a_fault), 16'd0);
        step(P_G1);

        // min-green on the tight instance
        apply_reset();
        step(P_G1); step(P_G1); step(P_Y1); step(P_Y1);
        chk("t4_short_fault", 16'(b_fault), 16'd1);
        chk("t4_short_code", 16'(b_code), 16'd4);
        chk("t4_a_fault", 16'(a_fault), 16'd0);
        apply_reset();
        step(P_G1); step(P_G1); step(P_G1); step(P_Y1); step(P_Y1);
        chk("t4_ok_fault", 16'(b_fault), 16'd0);

        // stuck yellow
        step(P_Y1); step(P_Y1); step(P_Y1);
        chk("t5_pre_dwell", b_dwell, 16'd4);
        chk("t5_pre_fault", 16'(b_fault), 16'd0);
        step(P_Y1);
        chk("t5_dwell", b_dwell, 16'd5);
        chk("t5_code", 16'(b_code), 16'd5);
        step(P_Y1, 0, 1); step(P_Y1); step(P_Y1);
        chk("t5_norepeat", 16'(b_fault), 16'd0);
        chk("t5_dwell_run", b_dwell, 16'd8);

        // clear coinciding with a malformed sample, then reset mid-run
        step(P_DARK); step(P_G1, 0, 1);
        chk("t6_a_code", 16'(a_code), 16'd2);
        chk("t6_b_fault", 16'(b_fault), 16'd1);
        step(P_Y1);
        apply_reset();

        ci = 0;
        for (int n = 0; n < 320; n++) begin
            r = $urandom_range(0, 99);
            if (r >= 55 && r < 85) ci = succ(ci);
            else if (r >= 85 && r < 93) ci = $urandom_range(0, 4);
            pat = (r >= 93) ? 6'($urandom) : pats[ci];
            step(pat, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
